// File: rtl/regbank_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : regbank_pkg                                            |
// | Description : Shared widths, command opcodes and FSM state encoding  |
// |               for the register-bank command master.                  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package regbank_pkg;

  localparam int RB_AW = 5;
  localparam int RB_DW = 32;

  typedef enum logic [1:0] {
    OP_READ2 = 2'b00,
    OP_WRITE = 2'b01,
    OP_FILL  = 2'b10,
    OP_COPY  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_FILL  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/regbank_cmd_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : regbank_cmd_master                                     |
// | Description : Accepts READ2/WRITE/FILL/COPY commands, sequences the  |
// |               register bank ports and returns one response each.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module regbank_cmd_master
  import regbank_pkg::*;
#(
  parameter int AW = RB_AW,
  parameter int DW = RB_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr_a,
  input  logic [AW-1:0] cmd_addr_b,
  input  logic [DW-1:0] cmd_data,
  input  logic [AW-1:0] cmd_len,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data_a,
  output logic [DW-1:0] rsp_data_b,
  output logic          rsp_err,
  output logic [AW-1:0] rb_sr1,
  output logic [AW-1:0] rb_sr2,
  output logic [AW-1:0] rb_dr,
  output logic          rb_wr,
  output logic [DW-1:0] rb_wrdata,
  input  logic [DW-1:0] rb_rddata1,
  input  logic [DW-1:0] rb_rddata2
);

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [AW-1:0] addr_a_q, addr_a_d;   // COPY destination, needed one cycle after accept
  logic [AW-1:0] cnt_q, cnt_d;         // FILL writes remaining after the current one
  logic          err_q, err_d;         // FILL destination wrapped past the top address
  logic [AW-1:0] sr1_q, sr1_d;
  logic [AW-1:0] sr2_q, sr2_d;
  logic [AW-1:0] dr_q, dr_d;
  logic          wr_q, wr_d;
  logic [DW-1:0] wrdata_q, wrdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_a_q, rsp_a_d;
  logic [DW-1:0] rsp_b_q, rsp_b_d;
  logic          rsp_err_q, rsp_err_d;

  op_e           cmd_op_e;
  assign cmd_op_e = op_e'(cmd_op);

  // State register; reset aborts any command in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode: one command at a time, response must drain before the next
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          unique case (cmd_op_e)
            OP_READ2: state_d = ST_READ;
            OP_WRITE: state_d = ST_WRITE;
            OP_FILL:  state_d = ST_FILL;
            OP_COPY:  state_d = ST_READ;
            default:  state_d = ST_IDLE;
          endcase
        end
      end
      ST_READ:  state_d = (op_q == OP_COPY) ? ST_WRITE : ST_RESP;
      ST_WRITE: state_d = ST_RESP;
      ST_FILL:  state_d = (cnt_q == '0) ? ST_RESP : ST_FILL;
      ST_RESP:  state_d = rsp_ready ? ST_IDLE : ST_RESP;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: bank port drive, FILL stepping and response capture
  always_comb begin
    op_d        = op_q;
    addr_a_d    = addr_a_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    sr1_d       = sr1_q;
    sr2_d       = sr2_q;
    dr_d        = dr_q;
    wr_d        = wr_q;
    wrdata_d    = wrdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_a_d     = rsp_a_q;
    rsp_b_d     = rsp_b_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d     = cmd_op_e;
          addr_a_d = cmd_addr_a;
          unique case (cmd_op_e)
            OP_READ2: begin
              sr1_d = cmd_addr_a;
              sr2_d = cmd_addr_b;
            end
            OP_WRITE: begin
              dr_d     = cmd_addr_a;
              wrdata_d = cmd_data;
              wr_d     = 1'b1;
            end
            OP_FILL: begin
              dr_d     = cmd_addr_a;
              wrdata_d = cmd_data;
              wr_d     = 1'b1;
              cnt_d    = cmd_len;
              err_d    = 1'b0;
            end
            OP_COPY: begin
              sr2_d = cmd_addr_b;
            end
            default: ;
          endcase
        end
      end
      ST_READ: begin
        if (op_q == OP_COPY) begin
          // Bank read is combinational, so the source value is valid this cycle
          dr_d     = addr_a_q;
          wrdata_d = rb_rddata2;
          wr_d     = 1'b1;
        end else begin
          rsp_a_d     = rb_rddata1;
          rsp_b_d     = rb_rddata2;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
        end
      end
      ST_WRITE: begin
        wr_d        = 1'b0;
        rsp_a_d     = wrdata_q;
        rsp_b_d     = '0;
        rsp_err_d   = 1'b0;
        rsp_valid_d = 1'b1;
      end
      ST_FILL: begin
        if (cnt_q != '0) begin
          dr_d     = dr_q + AW'(1);
          wrdata_d = wrdata_q + DW'(1);
          cnt_d    = cnt_q - AW'(1);
          // Stepping off the top address means the fill range wrapped
          if (dr_q == {AW{1'b1}}) err_d = 1'b1;
        end else begin
          wr_d        = 1'b0;
          rsp_a_d     = wrdata_q;
          rsp_b_d     = '0;
          rsp_err_d   = err_q;
          rsp_valid_d = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath registers; rb_wr drops the instant reset asserts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q        <= OP_READ2;
      addr_a_q    <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      sr1_q       <= '0;
      sr2_q       <= '0;
      dr_q        <= '0;
      wr_q        <= 1'b0;
      wrdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_a_q     <= '0;
      rsp_b_q     <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      op_q        <= op_d;
      addr_a_q    <= addr_a_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      sr1_q       <= sr1_d;
      sr2_q       <= sr2_d;
      dr_q        <= dr_d;
      wr_q        <= wr_d;
      wrdata_q    <= wrdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_a_q     <= rsp_a_d;
      rsp_b_q     <= rsp_b_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data_a = rsp_a_q;
  assign rsp_data_b = rsp_b_q;
  assign rsp_err    = rsp_err_q;
  assign rb_sr1     = sr1_q;
  assign rb_sr2     = sr2_q;
  assign rb_dr      = dr_q;
  assign rb_wr      = wr_q;
  assign rb_wrdata  = wrdata_q;

endmodule
`default_nettype wire
